// File: rtl/alu_ctrl_pkg.sv
// Purpose : shared widths and state encoding for the shared-ALU controller.
// Contents: DATA_W / OPC_W operand and opcode widths, CNT_W latency-counter
//           width (ALU latency up to 7), state_t controller state encoding.
package alu_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int OPC_W  = 4;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Purpose : combinational round-robin arbiter. The search starts just above
//           last_grant and wraps to index 0.
// Ports   : req        - request vector
//           last_grant - index granted most recently
//           enable     - when low, no grant is produced
//           grant      - one-hot grant (zero when nothing is granted)
//           grant_idx  - binary index of the grant
//           grant_vld  - a grant was produced
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic             hi_found_s;
  logic             lo_found_s;
  logic [IDX_W-1:0] hi_idx_s;
  logic [IDX_W-1:0] lo_idx_s;

  // Two priority passes: the lowest requester above last_grant wins,
  // otherwise the lowest requester overall (the wrap-around case).
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      hi_found_s = (req[i] && (IDX_W'(i) > last_grant)) ? 1'b1 : hi_found_s;
      hi_idx_s   = (req[i] && (IDX_W'(i) > last_grant)) ? IDX_W'(i) : hi_idx_s;
      lo_found_s = req[i] ? 1'b1 : lo_found_s;
      lo_idx_s   = req[i] ? IDX_W'(i) : lo_idx_s;
    end
    grant_vld = enable & (hi_found_s | lo_found_s);
    grant_idx = hi_found_s ? hi_idx_s : lo_idx_s;
    grant     = grant_vld ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Purpose : shares one ALU between NUM_REQ requesters. Requests are chosen by
//           round-robin in IDLE. The granted operands are held on the ALU inputs
//           for ALU_LATENCY+1 cycles (EXEC). The ALU result is then presented
//           to the winner until it is accepted (RESP).
// Ports   : clk, reset (async, active-low)
//           req_valid/req_ready/req_a/req_b/req_opcode - request side, packed per requester
//           rsp_valid/rsp_ready/rsp_y/rsp_co           - response side, shared data bus
//           busy                                       - controller not in IDLE
//           alu_a_in/alu_b_in/alu_opcode_in, alu_y_out/alu_co_out - ALU port group
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OPC_W-1:0]  req_opcode,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_y,
  output logic                      rsp_co,
  output logic                      busy,
  output logic [DATA_W-1:0]         alu_a_in,
  output logic [DATA_W-1:0]         alu_b_in,
  output logic [OPC_W-1:0]          alu_opcode_in,
  input  logic [DATA_W-1:0]         alu_y_out,
  input  logic                      alu_co_out
);

  localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Reset value of the pointer makes requester 0 the first one searched.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [DATA_W-1:0]   rsp_y_q, rsp_y_d;
  logic                rsp_co_q, rsp_co_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

  logic                arb_en_s;
  logic [NUM_REQ-1:0]  arb_grant_s;
  logic [IDX_W-1:0]    arb_idx_s;
  logic                arb_vld_s;
  logic [DATA_W-1:0]   sel_a_s;
  logic [DATA_W-1:0]   sel_b_s;
  logic [OPC_W-1:0]    sel_opc_s;

  // Gating with reset keeps req_ready low while reset is held.
  assign arb_en_s = (state_q == IDLE) & reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .enable     (arb_en_s),
    .grant      (arb_grant_s),
    .grant_idx  (arb_idx_s),
    .grant_vld  (arb_vld_s)
  );

  // Operand mux selecting the granted requester's lane.
  always_comb begin
    sel_a_s   = '0;
    sel_b_s   = '0;
    sel_opc_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a_s   = (arb_idx_s == IDX_W'(i)) ? req_a[i*DATA_W +: DATA_W]     : sel_a_s;
      sel_b_s   = (arb_idx_s == IDX_W'(i)) ? req_b[i*DATA_W +: DATA_W]     : sel_b_s;
      sel_opc_s = (arb_idx_s == IDX_W'(i)) ? req_opcode[i*OPC_W +: OPC_W]  : sel_opc_s;
    end
  end

  // Next-state and datapath updates for IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    opc_d        = opc_q;
    rsp_y_d      = rsp_y_q;
    rsp_co_d     = rsp_co_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (arb_vld_s) begin
          opa_d   = sel_a_s;
          opb_d   = sel_b_s;
          opc_d   = sel_opc_s;
          grant_d = arb_idx_s;
          cnt_d   = CNT_W'(ALU_LATENCY);
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        // The counter reaches zero in the last EXEC cycle. The ALU output is
        // valid on that cycle's closing edge.
        if (cnt_q == '0) begin
          rsp_y_d     = alu_y_out;
          rsp_co_d    = alu_co_out;
          rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d  = '0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      grant_q      <= '0;
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      opc_q        <= '0;
      rsp_y_q      <= '0;
      rsp_co_q     <= 1'b0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      opc_q        <= opc_d;
      rsp_y_q      <= rsp_y_d;
      rsp_co_q     <= rsp_co_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign req_ready     = arb_grant_s;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_y         = rsp_y_q;
  assign rsp_co        = rsp_co_q;
  assign busy          = (state_q != IDLE);
  assign alu_a_in      = opa_q;
  assign alu_b_in      = opb_q;
  assign alu_opcode_in = opc_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl. Three instances are built, with ALU latency
// 0, 1 and 3. Each instance has a behavioural ALU model with a delay line.
// The reference model tracks the round-robin pointer per instance and
// predicts the grant, the result and the cycle timing.
module tb_alu_share_ctrl;

  localparam int NR = 4;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NR-1:0]   req_valid [NI];
  logic [NR-1:0]   req_ready [NI];
  logic [NR*8-1:0] req_a     [NI];
  logic [NR*8-1:0] req_b     [NI];
  logic [NR*4-1:0] req_opc   [NI];
  logic [NR-1:0]   rsp_valid [NI];
  logic [NR-1:0]   rsp_ready [NI];
  logic [7:0]      rsp_y     [NI];
  logic            rsp_co    [NI];
  logic            busy      [NI];
  logic [7:0]      alu_a     [NI];
  logic [7:0]      alu_b     [NI];
  logic [3:0]      alu_opc   [NI];
  logic [7:0]      alu_y     [NI];
  logic            alu_co    [NI];

  int n_cmp = 0;
  int n_bad = 0;
  int last_g [NI];

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, anything else passes A.
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  // Round-robin reference: scan upward from last+1, wrapping modulo NR.
  function automatic int rr_pick(input int last, input logic [NR-1:0] mask);
    for (int d = 1; d <= NR; d++) begin
      if (mask[(last + d) % NR]) return (last + d) % NR;
    end
    return -1;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 0 : (gi == 1) ? 1 : 3;
    logic [8:0] now_s;
    logic [8:0] tap_s;
    logic [8:0] dly_q [1:7];

    assign now_s = alu_ref(alu_a[gi], alu_b[gi], alu_opc[gi]);

    always_ff @(posedge clk) begin
      dly_q[1] <= now_s;
      for (int s = 2; s <= 7; s++) dly_q[s] <= dly_q[s-1];
    end

    if (LAT == 0) begin : g_comb
      assign tap_s = now_s;
    end else begin : g_pipe
      assign tap_s = dly_q[LAT];
    end
    assign alu_y[gi]  = tap_s[7:0];
    assign alu_co[gi] = tap_s[8];

    alu_share_ctrl #(.NUM_REQ(NR), .ALU_LATENCY(LAT)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid[gi]),
      .req_ready     (req_ready[gi]),
      .req_a         (req_a[gi]),
      .req_b         (req_b[gi]),
      .req_opcode    (req_opc[gi]),
      .rsp_valid     (rsp_valid[gi]),
      .rsp_ready     (rsp_ready[gi]),
      .rsp_y         (rsp_y[gi]),
      .rsp_co        (rsp_co[gi]),
      .busy          (busy[gi]),
      .alu_a_in      (alu_a[gi]),
      .alu_b_in      (alu_b[gi]),
      .alu_opcode_in (alu_opc[gi]),
      .alu_y_out     (alu_y[gi]),
      .alu_co_out    (alu_co[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    check({tag, "_busy"},  32'(busy[k]),      32'd0);
    check({tag, "_rspv"},  32'(rsp_valid[k]), 32'd0);
  endtask

  // One full transaction on instance k. The request is presented with the given
  // mask. The response is stalled for 'stall' cycles before it is accepted.
  task automatic txn(input int k, input logic [NR-1:0] mask, input int stall,
                     input bit force_op, input logic [7:0] fa, input logic [7:0] fb,
                     input logic [3:0] fo, output logic [NR-1:0] got_ready);
    int          lat;
    int          g;
    bit          hold;
    logic [NR-1:0] oh;
    logic [7:0]  ea, eb;
    logic [3:0]  eo;
    logic [8:0]  er;
    lat = lat_of(k);
    @(negedge clk);
    req_valid[k] = mask;
    rsp_ready[k] = '0;
    if (force_op) begin
      req_a[k]   = {NR{fa}};
      req_b[k]   = {NR{fb}};
      req_opc[k] = {NR{fo}};
    end else begin
      req_a[k]   = $urandom;
      req_b[k]   = $urandom;
      req_opc[k] = 16'($urandom);
    end
    #1;
    got_ready = req_ready[k];
    g = rr_pick(last_g[k], mask);
    if (g < 0) begin
      check("noreq_ready", 32'(req_ready[k]), 32'd0);
      check_idle_outputs(k, "noreq");
      @(negedge clk);
      check_idle_outputs(k, "noreq_after");
      return;
    end
    oh = 4'b0001 << g;
    check("grant", 32'(req_ready[k]), 32'(oh));
    check("idle_busy", 32'(busy[k]), 32'd0);
    ea = req_a[k][g*8 +: 8];
    eb = req_b[k][g*8 +: 8];
    eo = req_opc[k][g*4 +: 4];
    er = alu_ref(ea, eb, eo);
    hold = 1'($urandom);
    // EXEC: ALU_LATENCY+1 cycles, no response yet, operands latched
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_valid[k] = hold ? mask : '0;
        req_a[k]     = $urandom;
        req_b[k]     = $urandom;
        rsp_ready[k] = 4'($urandom);
      end
      #1;
      check("exec_alu_a",  32'(alu_a[k]),     32'(ea));
      check("exec_alu_b",  32'(alu_b[k]),     32'(eb));
      check("exec_alu_op", 32'(alu_opc[k]),   32'(eo));
      check("exec_rspv",   32'(rsp_valid[k]), 32'd0);
      check("exec_ready",  32'(req_ready[k]), 32'd0);
      check("exec_busy",   32'(busy[k]),      32'd1);
    end
    // RESP: rsp_valid first high at T+ALU_LATENCY+2, held under backpressure
    for (int c = 0; c <= stall; c++) begin
      @(negedge clk);
      rsp_ready[k] = (c == stall) ? (4'($urandom) | oh) : (4'($urandom) & ~oh);
      #1;
      check("resp_valid", 32'(rsp_valid[k]), 32'(oh));
      check("resp_y",     32'(rsp_y[k]),     32'(er[7:0]));
      check("resp_co",    32'(rsp_co[k]),    32'(er[8]));
      check("resp_ready", 32'(req_ready[k]), 32'd0);
      check("resp_alu_a", 32'(alu_a[k]),     32'(ea));
    end
    @(negedge clk);
    rsp_ready[k] = '0;
    req_valid[k] = '0;
    #1;
    check_idle_outputs(k, "post");
    check("post_alu_hold", 32'(alu_a[k]), 32'(ea));
    last_g[k] = g;
  endtask

  logic [NR-1:0] gr;
  logic [NR-1:0] exp_fair [5];

  initial begin
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = '0;
      rsp_ready[k] = '0;
      req_a[k]     = '0;
      req_b[k]     = '0;
      req_opc[k]   = '0;
      last_g[k]    = NR - 1;
    end
    exp_fair[0] = 4'b0001; exp_fair[1] = 4'b0010; exp_fair[2] = 4'b0100;
    exp_fair[3] = 4'b1000; exp_fair[4] = 4'b0001;

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clk);
    req_valid[1] = 4'b1111;
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_ready", 32'(req_ready[k]), 32'd0);
      check("rst_rspv",  32'(rsp_valid[k]), 32'd0);
      check("rst_busy",  32'(busy[k]),      32'd0);
      check("rst_alu_a", 32'(alu_a[k]),     32'd0);
      check("rst_rsp_y", 32'(rsp_y[k]),     32'd0);
    end
    req_valid[1] = '0;
    @(negedge clk);
    reset = 1'b1;

    // Single op on requester 2, latency 1: 7F + 01 = 80, no carry
    txn(1, 4'b0100, 0, 1'b1, 8'h7F, 8'h01, 4'd0, gr);
    check("single_grant", 32'(gr), 32'h4);

    // Reset while an operation is in EXEC
    @(negedge clk);
    req_valid[2] = 4'b0010;
    req_a[2] = 32'h11223344; req_b[2] = 32'h55667788; req_opc[2] = 16'h0000;
    @(negedge clk);
    check("midrst_busy_pre", 32'(busy[2]), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_busy",  32'(busy[2]),      32'd0);
    check("midrst_ready", 32'(req_ready[2]), 32'd0);
    check("midrst_rspv",  32'(rsp_valid[2]), 32'd0);
    check("midrst_alu_a", 32'(alu_a[2]),     32'd0);
    check("midrst_alu_b", 32'(alu_b[2]),     32'd0);
    req_valid[2] = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < NI; k++) last_g[k] = NR - 1;
    repeat (6) begin
      @(negedge clk);
      #1;
      check_idle_outputs(2, "after_rst");
    end

    // Fairness with all requesters valid, then pointer wrap (last=3 -> 0 -> 3)
    for (int i = 0; i < 4; i++) begin
      txn(1, 4'b1111, 0, 1'b0, 8'h00, 8'h00, 4'd0, gr);
      check("fair_grant", 32'(gr), 32'(exp_fair[i]));
    end
    txn(1, 4'b1001, 1, 1'b0, 8'h00, 8'h00, 4'd0, gr);
    check("wrap_to_0", 32'(gr), 32'(exp_fair[4]));
    txn(1, 4'b1001, 0, 1'b0, 8'h00, 8'h00, 4'd0, gr);
    check("wrap_to_3", 32'(gr), 32'h8);

    // Backpressure for 5 cycles
    txn(1, 4'b0010, 5, 1'b0, 8'h00, 8'h00, 4'd0, gr);

    // Latency 0 and 3 with a carry-out case: FF + 01 = 00, co=1
    txn(0, 4'b0001, 0, 1'b1, 8'hFF, 8'h01, 4'd0, gr);
    txn(2, 4'b0100, 2, 1'b1, 8'hFF, 8'h01, 4'd0, gr);

    // Randomized traffic across all instances
    for (int n = 0; n < 60; n++) begin
      int k;
      logic [NR-1:0] m;
      k = int'($urandom_range(0, NI - 1));
      m = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      txn(k, m, int'($urandom_range(0, 4)), 1'b0, 8'h00, 8'h00, 4'd0, gr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
